// File: rtl/sparse_block_expander.sv
// sparse_block_expander
// Rebuilds a dense vector of IN_BLOCK_NUM blocks from a zero-block mask and
// a stream of compacted non-zero blocks. Each accepted block is scattered to
// the dense position of the next zero bit in the mask, in ascending order.
// Positions whose blocks are flagged zero, and non-zero positions beyond the
// OUT_BLOCK_NUM cap, are left zero.
module sparse_block_expander #(
  parameter int IN_BLOCK_NUM  = 3,
  parameter int BLOCK_SIZE    = 4,
  parameter int OUT_BLOCK_NUM = 2,
  parameter int IN_WIDTH      = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [IN_BLOCK_NUM-1:0]                   zero_mask,
  input  logic                                      zero_mask_valid,
  output logic                                      zero_mask_ready,
  input  logic [IN_WIDTH*BLOCK_SIZE-1:0]            data_in,
  input  logic                                      data_in_valid,
  output logic                                      data_in_ready,
  output logic [IN_WIDTH*IN_BLOCK_NUM*BLOCK_SIZE-1:0] data_out,
  output logic                                      data_out_valid,
  input  logic                                      data_out_ready
);

  localparam int CNT_W  = $clog2(OUT_BLOCK_NUM + 1);
  localparam int SLOT_W = (IN_BLOCK_NUM > 1) ? $clog2(IN_BLOCK_NUM) : 1;
  localparam int BLK_W  = IN_WIDTH * BLOCK_SIZE;
  localparam int VEC_W  = BLK_W * IN_BLOCK_NUM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Number of non-zero blocks in a mask, saturated to the compaction cap.
  function automatic logic [CNT_W-1:0] sat_nonzero_count(input logic [IN_BLOCK_NUM-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int b = 0; b < IN_BLOCK_NUM; b++) begin
      if (!m[b] && (c < CNT_W'(OUT_BLOCK_NUM))) begin
        c = c + CNT_W'(1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [IN_BLOCK_NUM-1:0] mask_r;
  logic [VEC_W-1:0]   dense_r;
  logic [VEC_W-1:0]   dense_next_s;
  logic [VEC_W-1:0]   data_out_r;
  logic               data_out_valid_r;
  logic               data_in_ready_r;
  logic               zero_mask_ready_r;

  logic               mask_hs_s;
  logic               fill_hs_s;
  logic               out_hs_s;
  logic [CNT_W-1:0]   k_in_s;
  logic [CNT_W-1:0]   k_cur_s;
  logic [SLOT_W-1:0]  slot_s [OUT_BLOCK_NUM];
  logic [SLOT_W-1:0]  slot_cur_s;
  logic [CNT_W-1:0]   scan_cnt_s;

  assign zero_mask_ready = zero_mask_ready_r;
  assign data_in_ready   = data_in_ready_r;
  assign data_out_valid  = data_out_valid_r;
  assign data_out        = data_out_r;

  // Handshake qualifiers and saturated block counts for incoming and latched masks.
  always_comb begin
    mask_hs_s = zero_mask_valid & zero_mask_ready_r;
    fill_hs_s = data_in_valid & data_in_ready_r;
    out_hs_s  = data_out_valid_r & data_out_ready;
    k_in_s    = sat_nonzero_count(zero_mask);
    k_cur_s   = sat_nonzero_count(mask_r);
  end

  // Priority scan of the latched mask: slot j holds the dense index of the j-th zero bit.
  always_comb begin
    scan_cnt_s = '0;
    for (int j = 0; j < OUT_BLOCK_NUM; j++) begin
      slot_s[j] = '0;
    end
    for (int b = 0; b < IN_BLOCK_NUM; b++) begin
      if (!mask_r[b] && (scan_cnt_s < CNT_W'(OUT_BLOCK_NUM))) begin
        slot_s[scan_cnt_s] = SLOT_W'(b);
        scan_cnt_s = scan_cnt_s + CNT_W'(1);
      end else begin
        scan_cnt_s = scan_cnt_s;
      end
    end
  end

  // Select the dense slot targeted by the current beat (range-safe mux on the counter).
  always_comb begin
    slot_cur_s = '0;
    for (int j = 0; j < OUT_BLOCK_NUM; j++) begin
      if (cnt_r == CNT_W'(j)) begin
        slot_cur_s = slot_s[j];
      end else begin
        slot_cur_s = slot_cur_s;
      end
    end
  end

  // Next-state decode of the mask / fill / output sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mask_hs_s) begin
          next_state_s = (k_in_s != '0) ? FILL : OUTPUT;
        end else begin
          next_state_s = IDLE;
        end
      end
      FILL: begin
        if (fill_hs_s && (cnt_r == (k_cur_s - CNT_W'(1)))) begin
          next_state_s = OUTPUT;
        end else begin
          next_state_s = FILL;
        end
      end
      OUTPUT: begin
        if (out_hs_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = OUTPUT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Dense buffer update: cleared on mask acceptance, one block scattered per fill beat.
  always_comb begin
    dense_next_s = dense_r;
    if ((state_r == IDLE) && mask_hs_s) begin
      dense_next_s = '0;
    end else if ((state_r == FILL) && fill_hs_s) begin
      for (int b = 0; b < IN_BLOCK_NUM; b++) begin
        if (slot_cur_s == SLOT_W'(b)) begin
          dense_next_s[b*BLK_W +: BLK_W] = data_in;
        end else begin
          dense_next_s[b*BLK_W +: BLK_W] = dense_r[b*BLK_W +: BLK_W];
        end
      end
    end else begin
      dense_next_s = dense_r;
    end
  end

  // State, counters, buffers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r           <= IDLE;
      cnt_r             <= '0;
      mask_r            <= '0;
      dense_r           <= '0;
      data_out_r        <= '0;
      data_out_valid_r  <= 1'b0;
      data_in_ready_r   <= 1'b0;
      zero_mask_ready_r <= 1'b1;
    end else begin
      state_r <= next_state_s;
      dense_r <= dense_next_s;
      if ((state_r == IDLE) && mask_hs_s) begin
        mask_r <= zero_mask;
        cnt_r  <= '0;
      end else if ((state_r == FILL) && fill_hs_s) begin
        cnt_r  <= cnt_r + CNT_W'(1);
      end
      // data_out only changes when a new vector is presented, so it holds through stalls
      // and keeps its last value after the output handshake.
      if ((next_state_s == OUTPUT) && (state_r != OUTPUT)) begin
        data_out_r <= dense_next_s;
      end
      data_out_valid_r  <= (next_state_s == OUTPUT);
      data_in_ready_r   <= (next_state_s == FILL);
      zero_mask_ready_r <= (next_state_s == IDLE);
    end
  end

endmodule

// File: tb/tb_sparse_block_expander.sv
// Directed bench for sparse_block_expander with a scoreboard of expected dense vectors.
module tb_sparse_block_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   zero_mask;
  logic         zero_mask_valid;
  logic         zero_mask_ready;
  logic [63:0]  data_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [191:0] data_out;
  logic         data_out_valid;
  logic         data_out_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [191:0] sb [$];
  logic [191:0] held;

  sparse_block_expander #(
    .IN_BLOCK_NUM(3), .BLOCK_SIZE(4), .OUT_BLOCK_NUM(2), .IN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .zero_mask(zero_mask), .zero_mask_valid(zero_mask_valid), .zero_mask_ready(zero_mask_ready),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  // Reference: walk blocks in ascending order, place beats into the first two zero-flagged slots.
  function automatic logic [191:0] model(input logic [2:0] m, input logic [63:0] b0,
                                         input logic [63:0] b1);
    logic [191:0] v;
    int used;
    v = '0;
    used = 0;
    for (int b = 0; b < 3; b++) begin
      if (!m[b] && used < 2) begin
        v[b*64 +: 64] = (used == 0) ? b0 : b1;
        used++;
      end
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_mask(input logic [2:0] m);
    int w;
    w = 0;
    zero_mask = m;
    zero_mask_valid = 1'b1;
    while (zero_mask_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("mask_hs_timeout", (w >= 50), 0);
    @(posedge clk); #1;
    zero_mask_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    int w;
    w = 0;
    data_in = d;
    data_in_valid = 1'b1;
    while (data_in_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("beat_hs_timeout", (w >= 50), 0);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic recv(input string tag);
    int w;
    logic [191:0] e;
    w = 0;
    e = '0;
    data_out_ready = 1'b1;
    while (data_out_valid !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_valid_timeout"}, (w >= 50), 0);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) e = sb.pop_front();
    chk({tag, "_data"}, data_out, e);
    @(posedge clk); #1;
    data_out_ready = 1'b0;
    chk({tag, "_valid_drop"}, data_out_valid, 0);
    chk({tag, "_idle_mask_ready"}, zero_mask_ready, 1);
    chk({tag, "_data_kept"}, data_out, e);
  endtask

  initial begin
    rst = 1'b0;
    zero_mask = 3'b000;
    zero_mask_valid = 1'b0;
    data_in = 64'd0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_in_ready", data_in_ready, 0);
    chk("rst_mask_ready", zero_mask_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // mask 010: blocks 0 and 2 filled, block 1 zero
    send_mask(3'b010);
    chk("t1_fill_ready", data_in_ready, 1);
    sb.push_back(model(3'b010, pk(16'd1, 16'd2, 16'd3, 16'd4), pk(16'd5, 16'd6, 16'd7, 16'd8)));
    send_beat(pk(16'd1, 16'd2, 16'd3, 16'd4));
    chk("t1_valid_early", data_out_valid, 0);
    send_beat(pk(16'd5, 16'd6, 16'd7, 16'd8));
    chk("t1_valid_latency", data_out_valid, 1);
    recv("t1");

    // mask 111: zero vector, no fill
    sb.push_back(model(3'b111, 64'd0, 64'd0));
    send_mask(3'b111);
    chk("t2_valid_latency", data_out_valid, 1);
    chk("t2_no_in_ready", data_in_ready, 0);
    recv("t2");

    // mask 000: only two beats consumed, third offered beat refused
    sb.push_back(model(3'b000, pk(16'd9, 16'd9, 16'd9, 16'd9), pk(16'd7, 16'd7, 16'd7, 16'd7)));
    send_mask(3'b000);
    send_beat(pk(16'd9, 16'd9, 16'd9, 16'd9));
    send_beat(pk(16'd7, 16'd7, 16'd7, 16'd7));
    data_in = pk(16'd5, 16'd5, 16'd5, 16'd5);
    data_in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t3_third_beat_refused", data_in_ready, 0);
    end
    data_in_valid = 1'b0;
    recv("t3");

    // mask 100: back-pressure for 5 cycles, mask offered during OUTPUT is ignored
    send_mask(3'b100);
    send_beat(pk(16'd11, 16'd12, 16'd13, 16'd14));
    send_beat(pk(16'd21, 16'd22, 16'd23, 16'd24));
    held = model(3'b100, pk(16'd11, 16'd12, 16'd13, 16'd14), pk(16'd21, 16'd22, 16'd23, 16'd24));
    sb.push_back(held);
    zero_mask = 3'b111;
    zero_mask_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t4_stall_data", data_out, held);
      chk("t4_stall_valid", data_out_valid, 1);
      chk("t4_stall_mask_ready", zero_mask_ready, 0);
      chk("t4_stall_in_ready", data_in_ready, 0);
    end
    zero_mask_valid = 1'b0;
    recv("t4");

    // mask 001: data_in_valid pattern 1,0,0,1
    sb.push_back(model(3'b001, pk(16'd31, 16'd32, 16'd33, 16'd34), pk(16'd41, 16'd42, 16'd43, 16'd44)));
    send_mask(3'b001);
    send_beat(pk(16'd31, 16'd32, 16'd33, 16'd34));
    repeat (2) begin
      @(posedge clk); #1;
      chk("t5_gap_in_ready", data_in_ready, 1);
      chk("t5_gap_valid", data_out_valid, 0);
    end
    send_beat(pk(16'd41, 16'd42, 16'd43, 16'd44));
    recv("t5");

    // reset mid-transaction, then a fresh mask 110 transaction
    send_mask(3'b010);
    send_beat(pk(16'd1, 16'd2, 16'd3, 16'd4));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("t6_rst_data_out", data_out, 0);
    chk("t6_rst_valid", data_out_valid, 0);
    chk("t6_rst_mask_ready", zero_mask_ready, 1);
    chk("t6_rst_in_ready", data_in_ready, 0);
    sb.push_back(model(3'b110, pk(16'd4, 16'd3, 16'd2, 16'd1), 64'd0));
    send_mask(3'b110);
    send_beat(pk(16'd4, 16'd3, 16'd2, 16'd1));
    recv("t6");

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sparse_block_expander.md
Name: sparse_block_expander

Overview:
- Inverse of the block-sparse compactor. Rebuilds a dense vector of IN_BLOCK_NUM blocks from a stream of compacted non-zero blocks.
- A zero-block mask is accepted first. One compacted block is then accepted per beat and scattered to its dense position. Zero blocks are zero-filled.
- Sits on the decompression side of the sparse arithmetic datapath, feeding dense consumers.

Parameters:
- IN_BLOCK_NUM, 3, number of blocks in the dense output vector
- BLOCK_SIZE, 4, elements per block
- OUT_BLOCK_NUM, 2, maximum number of compacted (non-zero) blocks per vector
- IN_WIDTH, 16, bits per element

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- zero_mask  input  IN_BLOCK_NUM  bit b=1: dense block b is zero; bit b=0: block b is non-zero
- zero_mask_valid  input  1  mask valid
- zero_mask_ready  output  1  mask ready
- data_in  input  IN_WIDTH x BLOCK_SIZE  one compacted block per beat
- data_in_valid  input  1  block valid
- data_in_ready  output  1  block ready
- data_out  output  IN_WIDTH x (IN_BLOCK_NUM*BLOCK_SIZE)  dense vector
- data_out_valid  output  1  dense vector valid
- data_out_ready  input  1  downstream ready

Behaviour:
- One clock, clk. rst is synchronous and active-low.
- Reset (rst=0 at a clk edge):
  - state=IDLE; beat counter=0; latched mask=0.
  - dense buffer all zero; data_out all zero.
  - data_out_valid=0, data_in_ready=0, zero_mask_ready=1 after the edge.
  - Reset mid-transaction discards all partial data.
- Handshakes: a transfer occurs on a clk edge where valid=1 and ready=1. Ready never depends combinationally on the same interface's valid.
- K = number of 0 bits in the latched mask, saturated to OUT_BLOCK_NUM.
- Slot list: the dense positions of the first K zero bits, in ascending block index order.
- Non-zero-flagged positions beyond the cap stay zero.
- IDLE:
  - zero_mask_ready=1, data_in_ready=0, data_out_valid=0.
  - On mask handshake: latch mask, clear the dense buffer, beat counter=0.
  - Next state is FILL if K>0, else OUTPUT.
- FILL:
  - data_in_ready=1, zero_mask_ready=0.
  - On each data_in handshake, write data_in element e to dense element slot[cnt]*BLOCK_SIZE+e, then cnt++.
  - On the handshake with cnt==K-1, go to OUTPUT.
  - data_in_valid gaps stall FILL with no state change.
- OUTPUT:
  - data_out_valid=1. data_out is driven from the dense buffer (registered) and held stable while data_out_ready=0.
  - zero_mask_ready=0, data_in_ready=0.
  - On output handshake go to IDLE. data_out keeps its last value; only valid drops.
- Latency with no stalls:
  - mask accepted at edge t; blocks accepted at edges t+1..t+K.
  - data_out_valid=1 from the cycle after edge t+K, or the cycle after edge t when K=0.
  - Throughput is one vector per K+2 cycles.
- Boundary conditions:
  - Mask all ones (K=0): a zero vector is emitted with no data_in beats.
  - Zero bits exceeding OUT_BLOCK_NUM: only OUT_BLOCK_NUM beats are consumed.
  - zero_mask_valid asserted outside IDLE is ignored (not accepted).
  - data_in_valid in IDLE/OUTPUT is not accepted.
- Width rules:
  - Beat counter width is clog2(OUT_BLOCK_NUM+1).
  - Slot indices are clog2(IN_BLOCK_NUM) bits, computed from the latched mask by a priority scan.

Test Plan (IN_BLOCK_NUM=3, BLOCK_SIZE=4, OUT_BLOCK_NUM=2, IN_WIDTH=16):
- mask 3'b010, beats [1,2,3,4], [5,6,7,8] back-to-back → elements 0..3=1,2,3,4; 4..7=0; 8..11=5,6,7,8; data_out_valid rises the cycle after the second beat.
- mask 3'b111 → no data_in_ready pulse, data_out all 0, data_out_valid the cycle after mask acceptance.
- mask 3'b000, beats [9,9,9,9], [7,7,7,7] → blocks 0,1 filled, block 2 zero, exactly 2 beats consumed, third offered beat not accepted.
- mask 3'b100, data_out_ready held 0 for 5 cycles after valid → data_out stable, valid held, zero_mask_ready=0 and data_in_ready=0 throughout; IDLE reached one cycle after ready rises.
- mask 3'b001, data_in_valid toggled 1,0,0,1 → blocks 1 and 2 correct, no corruption during gaps.
- rst=0 after first beat of a mask 3'b010 transaction → data_out all zero, valid 0, zero_mask_ready 1; the following transaction (mask 3'b110, beat [4,3,2,1]) yields block 0=4,3,2,1 and the rest zero.
